// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 core: opcode nibbles, ALU sub-ops, FSM states, LFSR constants.
package chip8_pkg;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_FAULT
    } state_t;

    localparam logic [3:0] OP_SYS     = 4'h0;
    localparam logic [3:0] OP_JP      = 4'h1;
    localparam logic [3:0] OP_CALL    = 4'h2;
    localparam logic [3:0] OP_SE_IMM  = 4'h3;
    localparam logic [3:0] OP_SNE_IMM = 4'h4;
    localparam logic [3:0] OP_SE_REG  = 4'h5;
    localparam logic [3:0] OP_LD_IMM  = 4'h6;
    localparam logic [3:0] OP_ADD_IMM = 4'h7;
    localparam logic [3:0] OP_ALU     = 4'h8;
    localparam logic [3:0] OP_SNE_REG = 4'h9;
    localparam logic [3:0] OP_LD_I    = 4'hA;
    localparam logic [3:0] OP_JP_V0   = 4'hB;
    localparam logic [3:0] OP_RND     = 4'hC;

    localparam logic [3:0] ALU_MOV  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_ADD  = 4'h4;
    localparam logic [3:0] ALU_SUB  = 4'h5;
    localparam logic [3:0] ALU_SHR  = 4'h6;
    localparam logic [3:0] ALU_SUBN = 4'h7;
    localparam logic [3:0] ALU_SHL  = 4'hE;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] RND_CONST = 8'h09;

    function automatic logic alu_op_valid(input logic [3:0] op);
        return (op <= ALU_SUBN) || (op == ALU_SHL);
    endfunction

    function automatic logic alu_writes_flag(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SHR) ||
               (op == ALU_SUBN) || (op == ALU_SHL);
    endfunction

endpackage

// File: rtl/chip8_alu.sv
// Combinational 8xyN ALU: produces the Vx result and the VF flag candidate.
module chip8_alu
    import chip8_pkg::*;
(
    input  logic [7:0] vx,
    input  logic [7:0] vy,
    input  logic [3:0] op,
    output logic [7:0] result,
    output logic       flag
);

    always_comb begin
        result = vx;
        flag   = 1'b0;
        case (op)
            ALU_MOV:  result = vy;
            ALU_OR:   result = vx | vy;
            ALU_AND:  result = vx & vy;
            ALU_XOR:  result = vx ^ vy;
            ALU_ADD:  {flag, result} = {1'b0, vx} + {1'b0, vy};
            ALU_SUB: begin
                result = vx - vy;
                flag   = (vx >= vy);
            end
            ALU_SHR: begin
                result = {1'b0, vx[7:1]};
                flag   = vx[0];
            end
            ALU_SUBN: begin
                result = vy - vx;
                flag   = (vy >= vx);
            end
            ALU_SHL: begin
                result = {vx[6:0], 1'b0};
                flag   = vx[7];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/chip8_core.sv
// Three-cycle CHIP-8 subset core with call stack and sticky fault state.
// Define CHIP8_LFSR_RAND_EN to source Cxkk from an 8-bit LFSR instead of a constant.
module chip8_core
    import chip8_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 16,
    parameter int OUT_REG     = 1
)(
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [7:0]      salida,
    output logic [PC_W-1:0] pc_out,
    output logic [11:0]     i_out,
    output logic            fault
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [11:0]       i_reg;
    logic [7:0]        v [16];
    logic [SP_W-1:0]   sp;
    logic [PC_W-1:0]   stack [STACK_DEPTH];
    logic [7:0]        rnd;

    logic              ir_load, exec_en, in_fault;
    logic [3:0]        op, x, y, n;
    logic [7:0]        kk, vx, vy, alu_res;
    logic [11:0]       nnn;
    logic              alu_flag;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [PC_W-1:0]   pc_inc, pc_skip, pc_nxt;
    logic [7:0]        vx_val;
    logic              vx_we, vf_we, i_we, push, pop, bad, commit;

    assign op  = ir[15:12];
    assign x   = ir[11:8];
    assign y   = ir[7:4];
    assign n   = ir[3:0];
    assign kk  = ir[7:0];
    assign nnn = ir[11:0];
    assign vx  = v[x];
    assign vy  = v[y];

    assign pc_inc   = pc + PC_W'(2);
    assign pc_skip  = pc + PC_W'(4);
    assign push_idx = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - 1'b1);

    chip8_alu u_alu (
        .vx     (vx),
        .vy     (vy),
        .op     (n),
        .result (alu_res),
        .flag   (alu_flag)
    );

`ifdef CHIP8_LFSR_RAND_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
    assign rnd = lfsr;
`else
    assign rnd = RND_CONST;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = bad ? ST_FAULT : ST_FETCH;
            ST_FAULT:  state_nxt = ST_FAULT;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        ir_load  = (state == ST_DECODE);
        exec_en  = (state == ST_EXEC);
        in_fault = (state == ST_FAULT);
    end

    always_comb begin
        pc_nxt = pc_inc;
        vx_we  = 1'b0;
        vx_val = alu_res;
        vf_we  = 1'b0;
        i_we   = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        bad    = 1'b0;
        case (op)
            OP_SYS: begin
                if (ir == 16'h00EE) begin
                    if (sp == '0) bad = 1'b1;
                    else begin
                        pop    = 1'b1;
                        pc_nxt = stack[top_idx];
                    end
                end else if (ir != 16'h00E0) begin
                    bad = 1'b1;
                end
            end
            OP_JP: pc_nxt = PC_W'(nnn);
            OP_CALL: begin
                if (sp == SP_FULL) bad = 1'b1;
                else begin
                    push   = 1'b1;
                    pc_nxt = PC_W'(nnn);
                end
            end
            OP_SE_IMM:  if (vx == kk) pc_nxt = pc_skip;
            OP_SNE_IMM: if (vx != kk) pc_nxt = pc_skip;
            OP_SE_REG: begin
                if (n != 4'h0)     bad    = 1'b1;
                else if (vx == vy) pc_nxt = pc_skip;
            end
            OP_SNE_REG: begin
                if (n != 4'h0)     bad    = 1'b1;
                else if (vx != vy) pc_nxt = pc_skip;
            end
            OP_LD_IMM: begin
                vx_we  = 1'b1;
                vx_val = kk;
            end
            OP_ADD_IMM: begin
                vx_we  = 1'b1;
                vx_val = vx + kk;
            end
            OP_ALU: begin
                if (!alu_op_valid(n)) bad = 1'b1;
                else begin
                    vx_we = 1'b1;
                    vf_we = alu_writes_flag(n);
                end
            end
            OP_LD_I:  i_we = 1'b1;
            OP_JP_V0: pc_nxt = PC_W'({1'b0, nnn} + {5'b0, v[0]});
            OP_RND: begin
                vx_we  = 1'b1;
                vx_val = rnd & kk;
            end
            default: bad = 1'b1;
        endcase
    end

    assign commit = exec_en && !bad;

    // VF is written after Vx so the flag wins when x == F
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ir    <= '0;
            i_reg <= '0;
            sp    <= '0;
            for (int unsigned k = 0; k < 16; k++) v[k] <= '0;
        end else begin
            if (ir_load) ir <= imem_rdata;
            if (commit) begin
                pc <= pc_nxt;
                if (i_we)  i_reg <= nnn;
                if (push)  sp    <= sp + 1'b1;
                if (pop)   sp    <= sp - 1'b1;
                if (vx_we) v[x]  <= vx_val;
                if (vf_we) v[15] <= alu_flag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && push) stack[push_idx] <= pc_inc;
    end

    // Outputs are forced low while rst is high so they read zero before the first reset edge
    assign imem_addr = rst ? '0 : pc;
    assign pc_out    = rst ? '0 : pc;
    assign i_out     = rst ? '0 : i_reg;
    assign salida    = rst ? '0 : v[4'(OUT_REG)];
    assign fault     = rst ? 1'b0 : in_fault;

endmodule

// File: tb/tb_chip8_core.sv
// Directed self-checking bench for chip8_core with a registered byte-wide instruction memory.
module tb_chip8_core;

    logic        clk;
    logic        rst;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  salida;
    logic [11:0] pc_out;
    logic [11:0] i_out;
    logic        fault;

    logic [7:0]  mem [4096];
    logic [11:0] addr_nxt;
    int          checks;
    int          errors;

    chip8_core #(
        .PC_W        (12),
        .STACK_DEPTH (16),
        .OUT_REG     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .salida     (salida),
        .pc_out     (pc_out),
        .i_out      (i_out),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign addr_nxt = imem_addr + 12'd1;
    always @(posedge clk) imem_rdata <= {mem[imem_addr], mem[addr_nxt]};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    endtask

    task automatic put(input logic [11:0] a, input logic [15:0] w);
        logic [11:0] b;
        b = a + 12'd1;
        mem[a] = w[15:8];
        mem[b] = w[7:0];
    endtask

    task automatic start();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic run(input int instrs);
        step(3 * instrs);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        // Arithmetic and carry: results copied into V1 for observation
        clear_mem();
        put(12'h000, 16'h6105); put(12'h002, 16'h6203);
        put(12'h004, 16'h8124); put(12'h006, 16'h81F0);
        put(12'h008, 16'h61FF); put(12'h00A, 16'h6201);
        put(12'h00C, 16'h8124); put(12'h00E, 16'h81F0);
        #1;
        check("rst_during_salida", 16'(salida), 16'h0000);
        check("rst_during_fault", 16'(fault), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_salida", 16'(salida), 16'h0000);
        check("rst_pc", 16'(pc_out), 16'h0000);
        check("rst_i", 16'(i_out), 16'h0000);
        check("rst_fault", 16'(fault), 16'h0000);
        check("rst_imem_addr", 16'(imem_addr), 16'h0000);
        run(3);
        check("add_v1", 16'(salida), 16'h0008);
        run(1);
        check("add_vf", 16'(salida), 16'h0000);
        run(3);
        check("carry_v1", 16'(salida), 16'h0000);
        run(1);
        check("carry_vf", 16'(salida), 16'h0001);
        check("seq_pc", 16'(pc_out), 16'h0010);

        // Skips: 3305 taken, 4305 not taken
        clear_mem();
        put(12'h000, 16'h6305); put(12'h002, 16'h3305);
        put(12'h004, 16'h6377); put(12'h006, 16'h4305);
        put(12'h008, 16'h8130);
        start();
        run(2);
        check("skip_pc", 16'(pc_out), 16'h0006);
        run(1);
        check("noskip_pc", 16'(pc_out), 16'h0008);
        run(1);
        check("skip_v3", 16'(salida), 16'h0005);

        // Shifts and flag priority
        clear_mem();
        put(12'h000, 16'h6F81); put(12'h002, 16'h8FFE); put(12'h004, 16'h81F0);
        put(12'h006, 16'h6A03); put(12'h008, 16'h8A06); put(12'h00A, 16'h81A0);
        put(12'h00C, 16'h81F0); put(12'h00E, 16'h61C3); put(12'h010, 16'h811E);
        start();
        run(3);
        check("shl_vf_priority", 16'(salida), 16'h0001);
        run(3);
        check("shr_va", 16'(salida), 16'h0001);
        run(1);
        check("shr_vf", 16'(salida), 16'h0001);
        run(2);
        check("shl_v1", 16'(salida), 16'h0086);

        // SUB equal operands, SUBN, Annn, Bnnn
        clear_mem();
        put(12'h000, 16'h6105); put(12'h002, 16'h6205); put(12'h004, 16'h8125);
        put(12'h006, 16'h81F0); put(12'h008, 16'h6104); put(12'h00A, 16'h6205);
        put(12'h00C, 16'h8127); put(12'h00E, 16'hA123); put(12'h010, 16'h6004);
        put(12'h012, 16'hB100);
        start();
        run(3);
        check("sub_eq_v1", 16'(salida), 16'h0000);
        run(1);
        check("sub_eq_vf", 16'(salida), 16'h0001);
        run(3);
        check("subn_v1", 16'(salida), 16'h0001);
        run(1);
        check("ld_i", 16'(i_out), 16'h0123);
        run(2);
        check("jp_v0_pc", 16'(pc_out), 16'h0104);

        // Cxkk right after reset: EXEC sees the LFSR two steps past the seed
        clear_mem();
        put(12'h000, 16'hC1FF);
        start();
        run(1);
`ifdef CHIP8_LFSR_RAND_EN
        check("rnd_v1", 16'(salida), 16'h0075);
`else
        check("rnd_v1", 16'(salida), 16'h0009);
`endif

        // Call/return, then recursion until the stack overflows
        clear_mem();
        put(12'h000, 16'h2010); put(12'h002, 16'h2002); put(12'h010, 16'h00EE);
        start();
        run(1);
        check("call_pc", 16'(pc_out), 16'h0010);
        run(1);
        check("ret_pc", 16'(pc_out), 16'h0002);
        run(16);
        check("stack_full_nofault", 16'(fault), 16'h0000);
        check("stack_full_pc", 16'(pc_out), 16'h0002);
        run(1);
        check("push_full_fault", 16'(fault), 16'h0001);
        step(6);
        check("fault_pc_frozen", 16'(pc_out), 16'h0002);
        check("fault_imem_held", 16'(imem_addr), 16'h0002);
        check("fault_sticky", 16'(fault), 16'h0001);
        start();
        check("fault_cleared_by_rst", 16'(fault), 16'h0000);
        check("fault_rst_pc", 16'(pc_out), 16'h0000);

        // Pop on empty stack
        clear_mem();
        put(12'h000, 16'h00EE);
        start();
        step(2);
        check("pop_empty_pending", 16'(fault), 16'h0000);
        step(1);
        check("pop_empty_fault", 16'(fault), 16'h0001);
        check("pop_empty_pc", 16'(pc_out), 16'h0000);

        // Illegal opcode
        clear_mem();
        put(12'h000, 16'hF000);
        start();
        step(2);
        check("illegal_pending", 16'(fault), 16'h0000);
        step(1);
        check("illegal_fault", 16'(fault), 16'h0001);

        // Reset asserted while 7105 is in EXEC
        clear_mem();
        put(12'h000, 16'h6133); put(12'h002, 16'h7105);
        start();
        run(1);
        check("pre_rst_v1", 16'(salida), 16'h0033);
        step(2);
        rst = 1'b1;
        #1;
        check("mid_rst_during_salida", 16'(salida), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_v1", 16'(salida), 16'h0000);
        check("mid_rst_pc", 16'(pc_out), 16'h0000);
        check("mid_rst_fault", 16'(fault), 16'h0000);
        run(2);
        check("post_rst_v1", 16'(salida), 16'h0038);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
